// File: rtl/envelope_ctrl.sv
// Two-channel ADSR envelope sequencer driving the PWM mixer's env/enable inputs.
// Both channels share the tick time base and one byte-wide settings write port.
module envelope_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       gateA,
  input  logic       gateB,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] envA,
  output logic [3:0] envB,
  output logic       enableA,
  output logic       enableB
);

  localparam int unsigned NCH = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  typedef struct packed {
    state_t     st;
    logic [3:0] env;
    logic [3:0] cnt;
  } chan_t;

  logic [3:0] atk_q [NCH];
  logic [3:0] dec_q [NCH];
  logic [3:0] sus_q [NCH];
  logic [3:0] rel_q [NCH];
  logic [3:0] atk_d [NCH];
  logic [3:0] dec_d [NCH];
  logic [3:0] sus_d [NCH];
  logic [3:0] rel_d [NCH];

  chan_t      ch_q  [NCH];
  chan_t      ch_d  [NCH];
  logic       en_q  [NCH];
  logic [1:0] gate;
  logic [1:0] gate_q;

  assign gate = {gateB, gateA};

  // One channel's next state: rise beats fall beats tick; a tick that
  // coincides with either gate edge is discarded.
  function automatic chan_t chan_next(
    input chan_t      cur,
    input logic       g,
    input logic       g_q,
    input logic       tk,
    input logic [3:0] atk,
    input logic [3:0] dec,
    input logic [3:0] sus,
    input logic [3:0] rel
  );
    chan_t      nxt;
    logic       rise;
    logic       fall;
    logic [3:0] rate;
    nxt  = cur;
    rise = g & ~g_q;
    fall = ~g & g_q;
    case (cur.st)
      ATTACK:  rate = atk;
      DECAY:   rate = dec;
      RELEASE: rate = rel;
      default: rate = '0;
    endcase

    if (rise) begin
      nxt.st  = ATTACK;
      nxt.cnt = '0;
    end else if (fall) begin
      if (cur.st == ATTACK || cur.st == DECAY || cur.st == SUSTAIN) begin
        nxt.st  = RELEASE;
        nxt.cnt = '0;
      end
    end else if (cur.st == SUSTAIN) begin
      nxt.env = sus;
      nxt.cnt = '0;
    end else if (tk && cur.st != IDLE) begin
      if (cur.cnt >= rate) begin
        nxt.cnt = '0;
        case (cur.st)
          ATTACK: begin
            if (cur.env == 4'd15) begin
              nxt.st = DECAY;
            end else begin
              nxt.env = cur.env + 4'd1;
              if (nxt.env == 4'd15) nxt.st = DECAY;
            end
          end
          DECAY: begin
            if (cur.env <= sus) begin
              nxt.st = SUSTAIN;
            end else begin
              nxt.env = cur.env - 4'd1;
              if (nxt.env <= sus) nxt.st = SUSTAIN;
            end
          end
          RELEASE: begin
            if (cur.env == 4'd0) begin
              nxt.st = IDLE;
            end else begin
              nxt.env = cur.env - 4'd1;
              if (nxt.env == 4'd0) nxt.st = IDLE;
            end
          end
          default: nxt = cur;
        endcase
      end else begin
        nxt.cnt = cur.cnt + 4'd1;
      end
    end
    return nxt;
  endfunction

  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      atk_d[ch] = atk_q[ch];
      dec_d[ch] = dec_q[ch];
      sus_d[ch] = sus_q[ch];
      rel_d[ch] = rel_q[ch];
      if (wr_en && wr_addr[1] == 1'(ch)) begin
        if (!wr_addr[0]) begin
          atk_d[ch] = wr_data[7:4];
          dec_d[ch] = wr_data[3:0];
        end else begin
          sus_d[ch] = wr_data[7:4];
          rel_d[ch] = wr_data[3:0];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      ch_d[ch] = chan_next(ch_q[ch], gate[ch], gate_q[ch], tick,
                           atk_q[ch], dec_q[ch], sus_q[ch], rel_q[ch]);
    end
  end

  // Gate history follows the pin even in reset, so a gate already held high
  // across reset is not mistaken for a new note once reset is released.
  always_ff @(posedge clk) begin
    gate_q <= gate;
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        atk_q[ch] <= '0;
        dec_q[ch] <= '0;
        sus_q[ch] <= '1;
        rel_q[ch] <= '0;
        ch_q[ch]  <= '{st: IDLE, env: '0, cnt: '0};
        en_q[ch]  <= 1'b0;
      end
    end else begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        atk_q[ch] <= atk_d[ch];
        dec_q[ch] <= dec_d[ch];
        sus_q[ch] <= sus_d[ch];
        rel_q[ch] <= rel_d[ch];
        ch_q[ch]  <= ch_d[ch];
        en_q[ch]  <= (ch_d[ch].st != IDLE);
      end
    end
  end

  assign envA    = ch_q[0].env;
  assign envB    = ch_q[1].env;
  assign enableA = en_q[0];
  assign enableB = en_q[1];

endmodule
